// File: rtl/base_aser_pkg.sv
// Shared helpers for the base_aser serializer slice.
// Holds the phase-counter width rule so the top and the counter size it the same way.
package base_aser_pkg;

  // A phase counter needs at least one bit, even when ways is degenerate.
  function automatic int ph_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/base_aser_ph.sv
// Wrapping phase counter for base_aser.
// Wraps to zero from max explicitly, so non-power-of-2 ranges never overflow into unused codes.
module base_aser_ph #(
  parameter int pw  = 1,
  parameter int max = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          clr,
  output logic [pw-1:0] ph,
  output logic          last
);

  logic [pw-1:0] r_ph;
  logic          w_last;

  assign w_last = (r_ph == pw'(max));

  always_ff @(posedge clk) begin
    if (reset || clr) r_ph <= '0;
    else if (inc)     r_ph <= w_last ? '0 : r_ph + 1'b1;
  end

  assign ph   = r_ph;
  assign last = w_last;

endmodule

// File: rtl/base_vlat_en.sv
// Enable-gated data register without reset.
// Used where the held contents are only meaningful behind a separate valid flag.
module base_vlat_en #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (en) r_q <= d;
  end

  assign q = r_q;

endmodule

// File: rtl/base_aser.sv
// Valid/ready serializer: takes one beat of `ways` packed words and emits them word 0 first.
// The last word's transfer can accept the next beat in the same cycle, so there is no bubble.
module base_aser
  import base_aser_pkg::*;
#(
  parameter int width = 1,
  parameter int ways  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_v,
  output logic                   i_r,
  input  logic [width*ways-1:0]  i_d,
  output logic                   o_v,
  input  logic                   o_r,
  output logic [width-1:0]       o_d,
  output logic                   o_first,
  output logic                   o_last
);

  localparam int pw = ph_w(ways);

  logic                  r_hv;
  logic [pw-1:0]         w_ph;
  logic                  w_last;
  logic                  w_in;
  logic                  w_out;
  logic [width*ways-1:0] w_hd;

  assign o_v   = r_hv;
  assign w_out = r_hv & o_r;
  // o_r reaches i_r combinationally so the next beat loads on the last word's transfer.
  assign i_r   = ~r_hv | (w_out & w_last);
  assign w_in  = i_v & i_r;

  always_ff @(posedge clk) begin
    if (reset)                r_hv <= 1'b0;
    else if (w_in)            r_hv <= 1'b1;
    else if (w_out && w_last) r_hv <= 1'b0;
  end

  base_aser_ph #(
    .pw  (pw),
    .max (ways - 1)
  ) u_ph (
    .clk   (clk),
    .reset (reset),
    .inc   (w_out),
    .clr   (w_in),
    .ph    (w_ph),
    .last  (w_last)
  );

  base_vlat_en #(
    .W (width * ways)
  ) u_hold (
    .clk (clk),
    .en  (w_in),
    .d   (i_d),
    .q   (w_hd)
  );

  always_comb begin
    o_d = '0;
    for (int k = 0; k < ways; k++) begin
      if (w_ph == pw'(k)) o_d = w_hd[k*width +: width];
    end
  end

  assign o_first = (w_ph == '0);
  assign o_last  = w_last;

endmodule

// File: tb/tb_base_aser.sv
// Self-checking bench for base_aser: three configurations checked against a word-queue model.
// Directed vectors pin the model with literal values; a long random run exercises ways=4.
module tb_base_aser;

  localparam int W0 = 8, N0 = 2;
  localparam int W1 = 4, N1 = 3;
  localparam int W2 = 8, N2 = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic                iv_a = 0, ir_a, ov_a, or_a = 0, of_a, ol_a;
  logic [W0*N0-1:0]    id_a = '0;
  logic [W0-1:0]       od_a;
  logic                iv_b = 0, ir_b, ov_b, or_b = 0, of_b, ol_b;
  logic [W1*N1-1:0]    id_b = '0;
  logic [W1-1:0]       od_b;
  logic                iv_c = 0, ir_c, ov_c, or_c = 0, of_c, ol_c;
  logic [W2*N2-1:0]    id_c = '0;
  logic [W2-1:0]       od_c;

  base_aser #(.width(W0), .ways(N0)) dut_a (
    .clk(clk), .reset(reset), .i_v(iv_a), .i_r(ir_a), .i_d(id_a),
    .o_v(ov_a), .o_r(or_a), .o_d(od_a), .o_first(of_a), .o_last(ol_a));
  base_aser #(.width(W1), .ways(N1)) dut_b (
    .clk(clk), .reset(reset), .i_v(iv_b), .i_r(ir_b), .i_d(id_b),
    .o_v(ov_b), .o_r(or_b), .o_d(od_b), .o_first(of_b), .o_last(ol_b));
  base_aser #(.width(W2), .ways(N2)) dut_c (
    .clk(clk), .reset(reset), .i_v(iv_c), .i_r(ir_c), .i_d(id_c),
    .o_v(ov_c), .o_r(or_c), .o_d(od_c), .o_first(of_c), .o_last(ol_c));

  int nchk = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each instance owns a queue of words still to be emitted, tagged first/last.
  typedef struct { logic [7:0] w; bit f; bit l; } ent_t;
  ent_t qa[$], qb[$], qc[$];
  bit   armed = 0;
  bit   acc_c = 0;
  int   beats_c = 0;

  function automatic bit exp_ir(input int sz, input logic orr);
    return (sz == 0) || (sz == 1 && orr);
  endfunction

  always @(posedge clk) begin
    bit acc;
    ent_t e;
    if (reset) begin
      qa.delete(); qb.delete(); qc.delete();
      acc_c = 0;
      armed = 1;
    end else begin
      acc = iv_a && exp_ir(qa.size(), or_a);
      if (qa.size() != 0 && or_a) void'(qa.pop_front());
      if (acc) for (int k = 0; k < N0; k++) begin
        e.w = 8'(id_a >> (k*W0)); e.f = (k == 0); e.l = (k == N0-1); qa.push_back(e);
      end
      acc = iv_b && exp_ir(qb.size(), or_b);
      if (qb.size() != 0 && or_b) void'(qb.pop_front());
      if (acc) for (int k = 0; k < N1; k++) begin
        e.w = 8'((id_b >> (k*W1)) & 12'hF); e.f = (k == 0); e.l = (k == N1-1); qb.push_back(e);
      end
      acc = iv_c && exp_ir(qc.size(), or_c);
      if (qc.size() != 0 && or_c) void'(qc.pop_front());
      if (acc) begin
        beats_c++;
        for (int k = 0; k < N2; k++) begin
          e.w = 8'(id_c >> (k*W2)); e.f = (k == 0); e.l = (k == N2-1); qc.push_back(e);
        end
      end
      acc_c = acc;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("a_ov", 32'(ov_a), 32'(qa.size() != 0));
      chk("a_ir", 32'(ir_a), 32'(exp_ir(qa.size(), or_a)));
      if (qa.size() != 0) begin
        chk("a_od", 32'(od_a), 32'(qa[0].w));
        chk("a_first", 32'(of_a), 32'(qa[0].f));
        chk("a_last", 32'(ol_a), 32'(qa[0].l));
      end
      chk("b_ov", 32'(ov_b), 32'(qb.size() != 0));
      chk("b_ir", 32'(ir_b), 32'(exp_ir(qb.size(), or_b)));
      if (qb.size() != 0) begin
        chk("b_od", 32'(od_b), 32'(qb[0].w));
        chk("b_first", 32'(of_b), 32'(qb[0].f));
        chk("b_last", 32'(ol_b), 32'(qb[0].l));
      end
      chk("c_ov", 32'(ov_c), 32'(qc.size() != 0));
      chk("c_ir", 32'(ir_c), 32'(exp_ir(qc.size(), or_c)));
      if (qc.size() != 0) begin
        chk("c_od", 32'(od_c), 32'(qc[0].w));
        chk("c_first", 32'(of_c), 32'(qc[0].f));
        chk("c_last", 32'(ol_c), 32'(qc[0].l));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek_a(input string n, input logic v, input logic [7:0] d,
                        input logic f, input logic l, input logic r);
    @(negedge clk);
    #1;
    chk({n, "_ov"}, 32'(ov_a), 32'(v));
    chk({n, "_ir"}, 32'(ir_a), 32'(r));
    if (v) begin
      chk({n, "_od"}, 32'(od_a), 32'(d));
      chk({n, "_first"}, 32'(of_a), 32'(f));
      chk({n, "_last"}, 32'(ol_a), 32'(l));
    end
  endtask

  task automatic peek_b(input string n, input logic v, input logic [3:0] d,
                        input logic f, input logic l);
    @(negedge clk);
    #1;
    chk({n, "_ov"}, 32'(ov_b), 32'(v));
    if (v) begin
      chk({n, "_od"}, 32'(od_b), 32'(d));
      chk({n, "_first"}, 32'(of_b), 32'(f));
      chk({n, "_last"}, 32'(ol_b), 32'(l));
    end
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_ov", 32'(ov_a), 32'd0);
    chk("rst_ir", 32'(ir_a), 32'd1);
    chk("rst_first", 32'(of_a), 32'd1);
    chk("rst_last", 32'(ol_a), 32'd0);

    // single beat, ways=2
    tick();
    iv_a = 1; id_a = 16'hB2A1; or_a = 1;
    tick(); iv_a = 0;
    peek_a("single_w0", 1, 8'hA1, 1, 0, 0);
    tick();
    peek_a("single_w1", 1, 8'hB2, 0, 1, 1);
    tick();
    peek_a("single_end", 0, 8'h00, 0, 0, 1);

    // back-to-back beats, no bubble
    iv_a = 1; id_a = 16'h2211;
    tick(); id_a = 16'h4433;
    peek_a("b2b_11", 1, 8'h11, 1, 0, 0);
    tick();
    peek_a("b2b_22", 1, 8'h22, 0, 1, 1);
    tick(); iv_a = 0;
    peek_a("b2b_33", 1, 8'h33, 1, 0, 0);
    tick();
    peek_a("b2b_44", 1, 8'h44, 0, 1, 1);
    tick();
    peek_a("b2b_end", 0, 8'h00, 0, 0, 1);

    // backpressure on word 0
    or_a = 0; iv_a = 1; id_a = 16'hB2A1;
    tick(); iv_a = 0;
    for (int i = 0; i < 3; i++) begin
      peek_a("stall_w0", 1, 8'hA1, 1, 0, 0);
      tick();
    end
    or_a = 1;
    peek_a("rel_w0", 1, 8'hA1, 1, 0, 0);
    tick();
    peek_a("rel_w1", 1, 8'hB2, 0, 1, 1);
    tick();
    peek_a("rel_end", 0, 8'h00, 0, 0, 1);

    // ways=3, non-power-of-2 wrap
    iv_b = 1; id_b = 12'h321; or_b = 1;
    tick(); iv_b = 0;
    peek_b("w3_1", 1, 4'h1, 1, 0);
    tick();
    peek_b("w3_2", 1, 4'h2, 0, 0);
    tick();
    peek_b("w3_3", 1, 4'h3, 0, 1);
    tick();
    peek_b("w3_end", 0, 4'h0, 0, 0);
    chk("w3_first_after_wrap", 32'(of_b), 32'd1);
    iv_b = 1; id_b = 12'hCBA;
    tick(); iv_b = 0;
    peek_b("w3_again", 1, 4'hA, 1, 0);
    tick(); tick(); tick();

    // reset mid-beat discards the remainder
    or_a = 0; iv_a = 1; id_a = 16'hB2A1;
    tick(); iv_a = 0;
    peek_a("mid_w0", 1, 8'hA1, 1, 0, 0);
    reset = 1;
    tick(); reset = 0;
    peek_a("mid_rst", 0, 8'h00, 0, 0, 1);
    or_a = 1; iv_a = 1; id_a = 16'h0605;
    tick(); iv_a = 0;
    peek_a("mid_05", 1, 8'h05, 1, 0, 0);
    tick();
    peek_a("mid_06", 1, 8'h06, 0, 1, 1);
    tick();
    peek_a("mid_end", 0, 8'h00, 0, 0, 1);

    // random traffic, ways=4; data held until accepted
    for (int i = 0; i < 12000; i++) begin
      if (!iv_c || acc_c) begin
        iv_c = ($urandom_range(0, 3) != 0);
        id_c = $urandom;
      end
      or_c = ($urandom_range(0, 3) != 0);
      tick();
    end
    iv_c = 0; or_c = 1;
    for (int i = 0; i < 8; i++) tick();
    @(negedge clk);
    #1;
    chk("rand_drained", 32'(ov_c), 32'd0);
    chk("rand_beats_seen", 32'(beats_c > 1000), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/base_aser.md
Name: base_aser

Overview:
- Single-clock valid/ready serializer: the width-narrowing counterpart of the two-word frequency-down converter.
- Accepts one beat of `ways` packed words and emits them one word per cycle, word 0 first, on a narrow valid/ready stream.
- Sits on the fast side of a width/rate boundary. It rebuilds the word stream that the down converter packed into {d1,d0}, when both ends run on one clock.
- Sustains full throughput: no bubble between consecutive input beats when the output is always ready.

Parameters:
- width, 1, bits per output word.
- ways, 2, words per input beat (>=2).
- pw, $clog2(ways), phase counter width (derived, not overridden).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- i_v  input  1  input beat valid.
- i_r  output  1  input beat ready.
- i_d  input  width*ways  packed words; word k = i_d[k*width +: width].
- o_v  output  1  output word valid.
- o_r  input  1  output word ready.
- o_d  output  width  current word.
- o_first  output  1  o_d is word 0 of its beat.
- o_last  output  1  o_d is word ways-1 of its beat.

Behaviour:
- Interface: one clock `clk`; reset is synchronous and active-high (`reset`).
- State:
  - hold register h_d (width*ways).
  - h_v flag.
  - phase counter ph (pw bits).
- Handshakes:
  - Input transfer when i_v&i_r; output transfer when o_v&o_r.
  - o_v must not depend on o_r.
  - Once asserted, o_v and o_d stay stable until transfer.
- Reset: h_v=0, ph=0, hence o_v=0, i_r=1, o_first=1, o_last=0; h_d is don't-care.
- Outputs:
  - o_v = h_v.
  - o_d = h_d[ph*width +: width].
  - o_first = (ph==0).
  - o_last = (ph==ways-1).
- i_r = ~h_v | (o_v & o_r & o_last). This is a combinational path from o_r to i_r, matching the codebase's other valid/ready stages.
- States (encoded by h_v, ph):
  - EMPTY (h_v=0):
    - Input transfer: load h_d, h_v=1, ph=0.
    - No input: stay.
  - SEND_k (h_v=1, ph=k<ways-1):
    - Output transfer: ph=k+1.
    - No transfer: hold.
  - SEND_LAST (h_v=1, ph=ways-1):
    - Output transfer with simultaneous input transfer: load h_d, ph=0, h_v stays 1 (back-to-back, no bubble).
    - Output transfer, no input: h_v=0, ph=0.
    - No transfer: hold.
- Latency: the first word of a beat is visible the cycle after input acceptance.
- Throughput: one word per cycle.
- Counter never exceeds ways-1. For non-power-of-2 ways, ph wraps to 0 explicitly, never by overflow.
- reset asserted mid-beat: the partially sent beat is discarded, no further words are emitted, and i_r=1 on the following cycle.
- i_v while h_v=1 and not last-accepting: i_r=0, and the input must hold (upstream contract).
- ways=2 with i_d={d1,d0} reproduces the d0,d1 order produced by the down converter.

Decomposition:
- No package typedefs needed.
- pw is a localparam computed from ways.
- One natural sub-module: `base_aser_ph`, a wrapping phase counter.
  - Inputs: clk, reset, inc, clr.
  - Outputs: ph, last. `last` is registered-free: a compare of ph against a `max` parameter.
- Hold register uses the existing `base_vlat_en` with en = i_v&i_r.

Test Plan:
- Reset then single beat, ways=2, width=8, i_d=16'hB2A1, o_r=1 → o_d=A1 (o_first=1) at cycle+1, then B2 (o_last=1) at cycle+2; o_v=0 after.
- Back-to-back beats 16'h2211, 16'h4433 with i_v held, o_r=1 → o_d=11,22,33,44 on consecutive cycles; i_r=1 exactly on the cycles with o_last=1 and when empty.
- Backpressure: o_r=0 for 3 cycles while word 0 is showing → o_v=1 and o_d=A1 stable, ph unchanged, i_r=0; release → A1,B2 follow.
- ways=3, width=4, i_d=12'h321 → o_d=1,2,3; ph goes 0,1,2,0 (no reaching 3); o_last only on 3.
- reset asserted while o_d=word 0 of 16'hB2A1 is showing → next cycle o_v=0, i_r=1; new beat 16'h0605 yields 05,06 with no B2 emitted.
- Random i_v/o_r (≥10k cycles), ways=4 → output word stream equals input beats unpacked lsb-first; o_v/o_d stable under stall; no loss or duplication.
